// File: rtl/dm_arbiter_pkg.sv
// Shared encodings and widths for the data-memory arbiter, its RAM and the board top.
`default_nettype none

package dm_arbiter_pkg;

  localparam int DM_ADDR_W = 6;
  localparam int DM_DATA_W = 32;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } dm_state_e;

endpackage

`default_nettype wire

// File: rtl/dm_arbiter_rr_arb2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the pointer owner.
`default_nettype none

module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      gnt_o = ptr_i ? 2'b10 : 2'b01;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dm_arbiter.sv
// Round-robin sequencer sharing the data-memory RAM between the core and the debug port.
`default_nettype none

module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int ADDR_W  = DM_ADDR_W,
  parameter int DATA_W  = DM_DATA_W,
  parameter int RAM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  input  logic [1:0]        req_we,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [DATA_W-1:0] req_wdata0,
  input  logic [DATA_W-1:0] req_wdata1,
  output logic [1:0]        req_ready,
  output logic [1:0]        rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              Mem_Write,
  output logic [ADDR_W-1:0] DM_Addr,
  output logic [DATA_W-1:0] M_W_Data,
  input  logic [DATA_W-1:0] M_R_Data
);

  if ((RAM_LAT < 1) || (RAM_LAT > 4)) begin : g_bad_ram_lat
    $error("dm_arbiter: RAM_LAT must be within 1..4");
  end

  dm_state_e         state_q, state_d;
  logic              ptr_q, ptr_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              win_q, win_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              mw_q, mw_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        gnt;
  logic              sel;

  rr_arb2 u_rr_arb2 (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (gnt)
  );

  assign sel = gnt[1];

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    win_d     = win_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    mw_d      = 1'b0;
    rdata_d   = rdata_q;
    req_ready = 2'b00;
    rsp_valid = 2'b00;

    case (state_q)
      S_IDLE: begin
        if (gnt != 2'b00) begin
          req_ready = gnt;
          win_d     = sel;
          we_d      = sel ? req_we[1]  : req_we[0];
          addr_d    = sel ? req_addr1  : req_addr0;
          wdata_d   = sel ? req_wdata1 : req_wdata0;
          // Write strobe is registered so it covers only the first ACCESS cycle.
          mw_d      = sel ? req_we[1]  : req_we[0];
          cnt_d     = 2'(RAM_LAT - 1);
          state_d   = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (cnt_q == 2'd0) begin
          if (!we_q) begin
            rdata_d = M_R_Data;
          end
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      S_RESP: begin
        rsp_valid = win_q ? 2'b10 : 2'b01;
        ptr_d     = ~win_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= 1'b0;
      cnt_q   <= 2'd0;
      win_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      mw_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mw_q    <= mw_d;
      rdata_q <= rdata_d;
    end
  end

  assign Mem_Write = mw_q;
  assign DM_Addr   = addr_q;
  assign M_W_Data  = wdata_q;
  assign rsp_rdata = rdata_q;

endmodule

`default_nettype wire
